// File: rtl/bf16_minmax_dispatch.sv
// bf16_minmax_dispatch: single-outstanding dispatcher between a request
// stream and a BF16 min/max execution unit with fixed latency LATENCY.
// Illegal opcodes are answered directly without touching the unit.
// Every output is a register, so nothing on the response side reaches
// the request side combinationally.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A source holds valid and its payload stable until that edge, and
// ready never depends combinationally on valid.
module bf16_minmax_dispatch #(
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [15:0] req_operand_a,
   input  logic [15:0] req_operand_b,
   input  logic [3:0]  req_operation,
   output logic        ex_enable,
   output logic [15:0] ex_operand_a,
   output logic [15:0] ex_operand_b,
   output logic [3:0]  ex_operation,
   input  logic [15:0] ex_result,
   input  logic [3:0]  ex_fpcsr,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [15:0] resp_result,
   output logic [3:0]  resp_fpcsr,
   output logic        resp_illegal,
   output logic [3:0]  sticky_fpcsr,
   input  logic        sticky_clear,
   output logic [1:0]  dbg_state
);

   localparam logic [3:0] OP_MAX  = 4'b0010;
   localparam logic [3:0] OP_MIN  = 4'b0011;
   localparam logic [3:0] LAT_CNT = 4'(LATENCY);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t     state;
   logic [3:0] wait_cnt;
   logic       op_legal;

   assign dbg_state = state;

   // Only min and max are executed; everything else is answered as illegal.
   assign op_legal = (req_operation == OP_MIN) || (req_operation == OP_MAX);

   // Dispatcher FSM with all outputs registered; the sticky-flag accumulator
   // lives here too so clear-then-OR on a capture edge is one statement.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         wait_cnt     <= 4'd0;
         req_ready    <= 1'b1;
         ex_enable    <= 1'b0;
         ex_operand_a <= 16'h0000;
         ex_operand_b <= 16'h0000;
         ex_operation <= 4'b0000;
         resp_valid   <= 1'b0;
         resp_result  <= 16'h0000;
         resp_fpcsr   <= 4'b0000;
         resp_illegal <= 1'b0;
         sticky_fpcsr <= 4'b0000;
      end else begin
         // A plain clear; a capture edge below overrides with clear-then-OR.
         if (sticky_clear) begin
            sticky_fpcsr <= 4'b0000;
         end
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  ex_operand_a <= req_operand_a;
                  ex_operand_b <= req_operand_b;
                  ex_operation <= req_operation;
                  req_ready    <= 1'b0;
                  if (op_legal) begin
                     ex_enable <= 1'b1;
                     state     <= S_ISSUE;
                  end else begin
                     resp_valid   <= 1'b1;
                     resp_illegal <= 1'b1;
                     resp_result  <= 16'h0000;
                     resp_fpcsr   <= 4'b0000;
                     state        <= S_RESP;
                  end
               end
            end
            S_ISSUE: begin
               ex_enable <= 1'b0;
               wait_cnt  <= LAT_CNT;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_cnt == 4'd1) begin
                  wait_cnt     <= 4'd0;
                  resp_valid   <= 1'b1;
                  resp_illegal <= 1'b0;
                  resp_result  <= ex_result;
                  resp_fpcsr   <= ex_fpcsr;
                  sticky_fpcsr <= (sticky_clear ? 4'b0000 : sticky_fpcsr) | ex_fpcsr;
                  state        <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bf16_minmax_dispatch.sv
// Directed bench for bf16_minmax_dispatch with a one-cycle BF16 min/max
// execution unit model attached. Outputs are sampled on the falling edge.
module tb_bf16_minmax_dispatch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [15:0] req_operand_a = 16'h0000;
   logic [15:0] req_operand_b = 16'h0000;
   logic [3:0]  req_operation = 4'b0000;
   logic        ex_enable;
   logic [15:0] ex_operand_a;
   logic [15:0] ex_operand_b;
   logic [3:0]  ex_operation;
   logic [15:0] ex_result;
   logic [3:0]  ex_fpcsr;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [15:0] resp_result;
   logic [3:0]  resp_fpcsr;
   logic        resp_illegal;
   logic [3:0]  sticky_fpcsr;
   logic        sticky_clear = 1'b0;
   logic [1:0]  dbg_state;

   logic [3:0]  flag_inject = 4'b0000;
   int          ex_pulses = 0;
   int          checks = 0;
   int          errors = 0;

   bf16_minmax_dispatch #(.LATENCY(1)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_operand_a (req_operand_a),
      .req_operand_b (req_operand_b),
      .req_operation (req_operation),
      .ex_enable     (ex_enable),
      .ex_operand_a  (ex_operand_a),
      .ex_operand_b  (ex_operand_b),
      .ex_operation  (ex_operation),
      .ex_result     (ex_result),
      .ex_fpcsr      (ex_fpcsr),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_result   (resp_result),
      .resp_fpcsr    (resp_fpcsr),
      .resp_illegal  (resp_illegal),
      .sticky_fpcsr  (sticky_fpcsr),
      .sticky_clear  (sticky_clear),
      .dbg_state     (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Execution unit model: BF16 min/max, any NaN input raises invalid (bit 2),
   // one NaN returns the other operand, two NaNs return canonical 7FC0.
   function automatic logic is_nan(input logic [15:0] x);
      return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
   endfunction

   function automatic logic lt(input logic [15:0] a, input logic [15:0] b);
      if (a[15] != b[15]) return a[15];
      if (!a[15]) return a[14:0] < b[14:0];
      return a[14:0] > b[14:0];
   endfunction

   function automatic logic [19:0] minmax(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
      logic [15:0] r;
      logic [3:0]  f;
      f = 4'b0000;
      if (is_nan(a) || is_nan(b)) f[2] = 1'b1;
      if (is_nan(a) && is_nan(b)) r = 16'h7FC0;
      else if (is_nan(a)) r = b;
      else if (is_nan(b)) r = a;
      else if (op == 4'b0011) r = lt(a, b) ? a : b;
      else r = lt(a, b) ? b : a;
      return {f, r};
   endfunction

   // Execution unit pipeline stage and issue-pulse counter
   always @(posedge clk) begin
      if (reset) begin
         ex_result <= 16'h0000;
         ex_fpcsr  <= 4'b0000;
      end else if (ex_enable) begin
         {ex_fpcsr, ex_result} <= minmax(ex_operand_a, ex_operand_b, ex_operation) |
                                  {flag_inject, 16'h0000};
      end
      if (ex_enable) ex_pulses <= ex_pulses + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Legal request with resp_ready=1; checks every cycle of the N..N+3 timeline.
   task automatic run_legal(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                            input logic clr, input logic [15:0] exp_res,
                            input logic [3:0] exp_flags, input logic [3:0] exp_sticky);
      int p0;
      p0 = ex_pulses;
      @(negedge clk);
      req_valid = 1'b1; req_operand_a = a; req_operand_b = b; req_operation = op;
      resp_ready = 1'b1; sticky_clear = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("issue_ex_enable", 32'(ex_enable), 32'd1);
      chk("issue_req_ready", 32'(req_ready), 32'd0);
      chk("issue_op_a", 32'(ex_operand_a), 32'(a));
      chk("issue_op_b", 32'(ex_operand_b), 32'(b));
      chk("issue_opcode", 32'(ex_operation), 32'(op));
      @(negedge clk);
      chk("wait_ex_enable", 32'(ex_enable), 32'd0);
      chk("wait_resp_valid", 32'(resp_valid), 32'd0);
      chk("wait_op_a_held", 32'(ex_operand_a), 32'(a));
      sticky_clear = clr;
      @(negedge clk);
      sticky_clear = 1'b0;
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_result", 32'(resp_result), 32'(exp_res));
      chk("resp_fpcsr", 32'(resp_fpcsr), 32'(exp_flags));
      chk("resp_illegal", 32'(resp_illegal), 32'd0);
      chk("resp_sticky", 32'(sticky_fpcsr), 32'(exp_sticky));
      chk("single_ex_pulse", 32'(ex_pulses - p0), 32'd1);
      @(negedge clk);
      chk("done_resp_valid", 32'(resp_valid), 32'd0);
      chk("done_req_ready", 32'(req_ready), 32'd1);
   endtask

   // Illegal opcode: response one cycle after acceptance, unit never issued.
   task automatic run_illegal(input logic [3:0] op, input logic [3:0] exp_sticky);
      int p0;
      p0 = ex_pulses;
      @(negedge clk);
      req_valid = 1'b1; req_operand_a = 16'h1234; req_operand_b = 16'h5678;
      req_operation = op; resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("ill_resp_valid", 32'(resp_valid), 32'd1);
      chk("ill_flag", 32'(resp_illegal), 32'd1);
      chk("ill_result", 32'(resp_result), 32'h0);
      chk("ill_fpcsr", 32'(resp_fpcsr), 32'h0);
      chk("ill_ex_enable", 32'(ex_enable), 32'd0);
      chk("ill_req_ready", 32'(req_ready), 32'd0);
      chk("ill_sticky", 32'(sticky_fpcsr), 32'(exp_sticky));
      @(negedge clk);
      chk("ill_done_valid", 32'(resp_valid), 32'd0);
      chk("ill_done_ready", 32'(req_ready), 32'd1);
      chk("ill_no_pulse", 32'(ex_pulses - p0), 32'd0);
   endtask

   task automatic chk_reset_values(input string pfx);
      chk({pfx, "_state"}, 32'(dbg_state), 32'd0);
      chk({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({pfx, "_ex_enable"}, 32'(ex_enable), 32'd0);
      chk({pfx, "_ex_op_a"}, 32'(ex_operand_a), 32'h0);
      chk({pfx, "_ex_op_b"}, 32'(ex_operand_b), 32'h0);
      chk({pfx, "_ex_opcode"}, 32'(ex_operation), 32'h0);
      chk({pfx, "_resp_valid"}, 32'(resp_valid), 32'd0);
      chk({pfx, "_resp_result"}, 32'(resp_result), 32'h0);
      chk({pfx, "_resp_fpcsr"}, 32'(resp_fpcsr), 32'h0);
      chk({pfx, "_resp_illegal"}, 32'(resp_illegal), 32'd0);
      chk({pfx, "_sticky"}, 32'(sticky_fpcsr), 32'h0);
   endtask

   initial begin
      // Reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_values("rst");
      reset = 1'b0;

      // Min / max on ordinary, negative and signed-zero operands
      run_legal(16'h3F80, 16'h4000, 4'b0011, 1'b0, 16'h3F80, 4'b0000, 4'b0000);
      run_legal(16'h3F80, 16'h4000, 4'b0010, 1'b0, 16'h4000, 4'b0000, 4'b0000);
      run_legal(16'hBF80, 16'h3F80, 4'b0011, 1'b0, 16'hBF80, 4'b0000, 4'b0000);
      run_legal(16'h8000, 16'h0000, 4'b0010, 1'b0, 16'h0000, 4'b0000, 4'b0000);

      // NaN operand: other operand returned, invalid flagged and made sticky
      run_legal(16'h7FC1, 16'h3F80, 4'b0010, 1'b0, 16'h3F80, 4'b0100, 4'b0100);

      // Illegal opcodes leave sticky flags alone
      run_illegal(4'b0000, 4'b0100);
      run_illegal(4'b1111, 4'b0100);

      // Backpressure with a second request held on req_valid
      @(negedge clk);
      req_valid = 1'b1; req_operand_a = 16'h4000; req_operand_b = 16'h3F80;
      req_operation = 4'b0011; resp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_operand_a = 16'hC000; req_operand_b = 16'h4040; req_operation = 4'b0010;
      chk("bp_issue_op_a", 32'(ex_operand_a), 32'h4000);
      @(negedge clk);
      chk("bp_wait_op_a", 32'(ex_operand_a), 32'h4000);
      chk("bp_wait_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_resp_result", 32'(resp_result), 32'h3F80);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(resp_valid), 32'd1);
         chk("bp_hold_result", 32'(resp_result), 32'h3F80);
         chk("bp_hold_fpcsr", 32'(resp_fpcsr), 32'h0);
         chk("bp_hold_illegal", 32'(resp_illegal), 32'd0);
         chk("bp_hold_req_ready", 32'(req_ready), 32'd0);
         chk("bp_hold_ex_enable", 32'(ex_enable), 32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_after_hs_state", 32'(dbg_state), 32'd0);
      chk("bp_after_hs_req_ready", 32'(req_ready), 32'd1);
      chk("bp_after_hs_valid", 32'(resp_valid), 32'd0);
      chk("bp_after_hs_ex_enable", 32'(ex_enable), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp_second_ex_enable", 32'(ex_enable), 32'd1);
      chk("bp_second_op_a", 32'(ex_operand_a), 32'hC000);
      chk("bp_second_opcode", 32'(ex_operation), 32'h2);
      @(negedge clk);
      @(negedge clk);
      chk("bp_second_valid", 32'(resp_valid), 32'd1);
      chk("bp_second_result", 32'(resp_result), 32'h4040);
      chk("bp_second_sticky", 32'(sticky_fpcsr), 32'h4);
      @(negedge clk);
      chk("bp_second_done", 32'(req_ready), 32'd1);

      // Reset while waiting on the execution unit
      @(negedge clk);
      req_valid = 1'b1; req_operand_a = 16'h3F80; req_operand_b = 16'h4000;
      req_operation = 4'b0011;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("mid_wait_state", 32'(dbg_state), 32'd2);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_values("rst_wait");
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
         chk("post_rst_idle", 32'(dbg_state), 32'd0);
      end

      // Sticky accumulation, clear coincident with capture, and clear alone
      flag_inject = 4'b0001;
      run_legal(16'h3F80, 16'h4000, 4'b0010, 1'b0, 16'h4000, 4'b0001, 4'b0001);
      flag_inject = 4'b0000;
      run_legal(16'h7FC1, 16'h3F80, 4'b0010, 1'b1, 16'h3F80, 4'b0100, 4'b0100);
      @(negedge clk);
      sticky_clear = 1'b1;
      @(negedge clk);
      sticky_clear = 1'b0;
      chk("sticky_clear_alone", 32'(sticky_fpcsr), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bf16_minmax_dispatch.md
BF16_MINMAX_DISPATCH -- requirements
Module: bf16_minmax_dispatch

Interface
REQ-001 Parameter LATENCY, default 1, cycles from ex_enable assertion until ex_result/ex_fpcsr are valid; legal range 1..8.
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  dispatcher can accept a request.
REQ-006 req_operand_a  input  16  BF16 operand A.
REQ-007 req_operand_b  input  16  BF16 operand B.
REQ-008 req_operation  input  4  opcode: 4'b0011 min, 4'b0010 max, all other values illegal.
REQ-009 ex_enable  output  1  one-cycle issue strobe to the min/max execution unit.
REQ-010 ex_operand_a, ex_operand_b  output  16 each  operands driven to the execution unit.
REQ-011 ex_operation  output  4  opcode driven to the execution unit.
REQ-012 ex_result  input  16  execution unit BF16 result.
REQ-013 ex_fpcsr  input  4  execution unit status flags (bit 2 = invalid).
REQ-014 resp_valid  output  1  response present.
REQ-015 resp_ready  input  1  consumer accepts response.
REQ-016 resp_result  output  16  captured BF16 result.
REQ-017 resp_fpcsr  output  4  captured flags for this operation.
REQ-018 resp_illegal  output  1  request had an illegal opcode and was not issued.
REQ-019 sticky_fpcsr  output  4  OR-accumulated flags of all captured responses since reset/clear.
REQ-020 sticky_clear  input  1  clears sticky_fpcsr.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT, RESP; exactly one request in flight at a time.
REQ-022 IDLE: req_ready=1; on req_valid at an edge, latch operands and opcode; legal opcode -> ISSUE, illegal -> RESP with resp_illegal=1, resp_result=16'h0000, resp_fpcsr=4'b0000.
REQ-023 req_ready SHALL be 0 in ISSUE, WAIT and RESP.
REQ-024 ISSUE: ex_enable=1 for exactly one cycle; load 4-bit wait counter with LATENCY; next state WAIT.
REQ-025 ex_operand_a/b and ex_operation SHALL hold the latched request values from ISSUE through the end of WAIT; ex_enable=0 in all states except ISSUE.
REQ-026 WAIT: counter decrements each cycle; at the edge where counter equals 1, capture ex_result and ex_fpcsr unmodified into resp_result/resp_fpcsr, set resp_illegal=0, go RESP.
REQ-027 Latency: request accepted at edge ending cycle N -> ex_enable in cycle N+1 -> resp_valid first high in cycle N+2+LATENCY (N+3 for LATENCY=1).
REQ-028 RESP: resp_valid=1; resp_result, resp_fpcsr and resp_illegal held stable until the edge with resp_ready=1, then IDLE; no combinational path from resp_ready to req_ready.
REQ-029 sticky_fpcsr |= ex_fpcsr at each WAIT capture edge; illegal-opcode responses SHALL NOT change it.
REQ-030 sticky_clear alone -> sticky_fpcsr=0 next cycle; sticky_clear coincident with capture -> sticky_fpcsr = captured ex_fpcsr (clear first, then OR).
REQ-031 req_valid asserted while not in IDLE is ignored; the request is not consumed.

Reset
REQ-032 reset wins over all other inputs in any state, including mid-WAIT; the in-flight operation is discarded and no response is produced.
REQ-033 Reset values next cycle: state IDLE, req_ready=1, ex_enable=0, ex_operand_a/b=16'h0000, ex_operation=4'b0000, resp_valid=0, resp_result=16'h0000, resp_fpcsr=4'b0000, resp_illegal=0, sticky_fpcsr=4'b0000, counter=0.

Verification (bench connects dispatcher to the bf16_minmax execution unit, LATENCY=1)
REQ-034 Min: a=16'h3F80, b=16'h4000, op=4'b0011, resp_ready=1 -> single ex_enable pulse; resp_valid in cycle N+3; resp_result=16'h3F80, resp_illegal=0.
REQ-035 Max then NaN: max(16'h3F80,16'h4000) -> 16'h4000; then a=16'h7FC1, b=16'h3F80, op=4'b0010 -> resp_result=16'h3F80, resp_fpcsr[2]=1, sticky_fpcsr[2]=1.
REQ-036 Illegal opcode 4'b0000 -> ex_enable never asserted; resp_valid in cycle N+1 with resp_illegal=1, resp_result=16'h0000; sticky_fpcsr unchanged.
REQ-037 Backpressure: resp_ready=0 for 5 cycles with req_valid=1 held -> resp_* stable, req_ready=0 throughout; second request accepted only in the cycle after resp_ready=1 handshake.
REQ-038 Reset during WAIT -> next cycle all outputs at REQ-033 values, no resp_valid pulse; sticky_clear coincident with a capture of fpcsr=4'b0100 -> sticky_fpcsr=4'b0100.
